systolic_matmul_tiled: RTL and testbench
========================================

Name: systolic_matmul_tiled

Overview:
Parametrised output-stationary systolic matmul engine and successor to the square single-size array. It computes C[ROWS x COLS] = A[ROWS x K] * W[K x COLS], with runtime inner dimension K (1..K_MAX), signed or unsigned operands, and an optional accumulate-onto-previous-result mode. Operand buffers are loaded through zero-based write ports. Results are read back through an addressed, registered read port instead of a flat bus. It sits behind the AXI register/DMA shim as the compute tile.

Parameters:
ROWS, 4, PE rows (output rows M)
COLS, 4, PE columns (output columns N)
K_MAX, 8, max inner dimension; act buffer depth ROWS*K_MAX, weight buffer depth K_MAX*COLS
DATA_WIDTH, 8, operand width (INT4 configs use 4)
ACC_WIDTH, 24, PE accumulator / result width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
w_wr_en  in  1  weight buffer write strobe
w_wr_addr  in  clog2(K_MAX*COLS)  zero-based; W[k][c] at k*COLS+c
w_wr_data  in  DATA_WIDTH  weight element
a_wr_en  in  1  activation buffer write strobe
a_wr_addr  in  clog2(ROWS*K_MAX)  zero-based; A[r][k] at r*K_MAX+k
a_wr_data  in  DATA_WIDTH  activation element
cfg_k  in  clog2(K_MAX+1)  inner dimension, sampled at start
cfg_signed  in  1  1 = two's-complement operands, sampled at start
cfg_acc  in  1  1 = accumulate onto existing PE contents, sampled at start
start  in  1  single-cycle request
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse on rejected start or on a write attempted while busy
res_rd_addr  in  clog2(ROWS*COLS)  C[r][c] at r*COLS+c
res_rd_data  out  ACC_WIDTH  registered read data, 1-cycle latency

Behaviour:
- Reset values: busy=0, done=0, err=0, res_rd_data=0, FSM=IDLE, all PE accumulators and pipeline registers 0, staging inputs 0. Buffer contents are not reset.
- Buffer writes use the posedge, have single-cycle effect, and are accepted only in IDLE. A write while busy is dropped and pulses err the next cycle. Out-of-range write addresses are dropped silently.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR when start=1 and 1<=cfg_k<=K_MAX. cfg_k/cfg_signed/cfg_acc are latched at that edge, and busy goes to 1.
- start with cfg_k=0 or cfg_k>K_MAX: stay in IDLE, err pulse, no state change. start while busy is ignored, with no err.
- CLEAR (1 cycle): if cfg_acc=0, the PE clear input is asserted and accumulators go to 0. If cfg_acc=1, accumulators are held. Pass-through registers are always zeroed.
- FEED (cfg_k+ROWS+COLS-2 cycles, counter t from 0):
  - north[c] = W[t-c][c] if 0<=t-c<cfg_k, else 0.
  - west[r] = A[r][t-r] if 0<=t-r<cfg_k, else 0.
  - Both are registered into staging before entering the array.
- DRAIN (2 cycles): zeros are fed while the staging and PE registers flush.
- DONE (1 cycle): done=1, busy falls with it, then -> IDLE.
- Latency: done is high exactly cfg_k+ROWS+COLS+1 rising edges after the start-accepting edge.
- PE: product is sign-extended when cfg_signed, zero-extended otherwise, to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH with no saturation. Operands are forwarded east/south with 1-cycle delay.
- Result read is valid in any state. Data equals the PE accumulator one cycle after the address is presented, and is only meaningful when busy=0. An out-of-range address returns 0.
- rst mid-operation: immediate return to IDLE, all outputs to reset values, accumulators cleared. A subsequent cfg_acc=1 run therefore starts from 0.

Decomposition:
- Package systolic_pkg: state encoding (IDLE..DONE), address-width helper functions, layout constants for buffer addressing.
- One sub-module mac_pe (DATA_WIDTH, ACC_WIDTH): ports clk, rst, clr, en_signed, north/west in, south/east out, acc.
- Top holds buffers, FSM, feed counter, staging and result mux.

Test Plan:
- Unsigned 4x4, K=4, A=I, W[k][c]=k*4+c+1, cfg_signed=0, cfg_acc=0 -> C[r][c]=r*4+c+1. done exactly 13 edges after start.
- Signed K=8, all A=-1 (0xFF), all W=3, cfg_signed=1 -> every C=-24 (0xFFFFE8). The same data with cfg_signed=0 -> every C=255*3*8=6120.
- Accumulate: run K=2 with A=W=1 (every C=2), then a second start with cfg_acc=1 and the same data -> every C=4. A third run with cfg_acc=0 -> every C=2.
- K=1 edge: A[r][0]=r+1, W[0][c]=c+1 -> C[r][c]=(r+1)(c+1), done after 10 edges. Separately, start with cfg_k=0 or 9 -> err pulse, busy stays 0.
- Busy write protection: a w_wr_en during FEED -> err pulse, buffer unchanged (a rerun gives the identical result).
- Reset mid-FEED: assert rst at t=3 -> busy=0, done=0, and all res_rd_data reads return 0 afterward. A fresh run then gives correct results.

Source files
------------

// File: rtl/systolic_matmul_tiled_pkg.sv
// Shared definitions for the tiled systolic matmul engine: FSM encoding,
// address-width helpers and the row-major buffer layout.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int DRAIN_CYCLES = 2;

   function automatic int addr_w(input int depth);
      if (depth > 1) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

   // W[k][c] lives at k*COLS+c
   function automatic int w_index(input int k, input int c, input int cols);
      return k * cols + c;
   endfunction

   // A[r][k] lives at r*K_MAX+k
   function automatic int a_index(input int r, input int k, input int k_max);
      return r * k_max + k;
   endfunction

endpackage

// File: rtl/systolic_matmul_tiled_if.sv
// Host-side port bundle of the compute tile: buffer writes, run control,
// status and the addressed result read port.
interface systolic_matmul_tiled_if import systolic_pkg::*; #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int K_MAX      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
);
   localparam int WAW = addr_w(K_MAX * COLS);
   localparam int AAW = addr_w(ROWS * K_MAX);
   localparam int KW  = addr_w(K_MAX + 1);
   localparam int RAW = addr_w(ROWS * COLS);

   logic                  w_wr_en;
   logic [WAW-1:0]        w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic                  a_wr_en;
   logic [AAW-1:0]        a_wr_addr;
   logic [DATA_WIDTH-1:0] a_wr_data;
   logic [KW-1:0]         cfg_k;
   logic                  cfg_signed;
   logic                  cfg_acc;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [RAW-1:0]        res_rd_addr;
   logic [ACC_WIDTH-1:0]  res_rd_data;

   modport master (
      output w_wr_en, w_wr_addr, w_wr_data, a_wr_en, a_wr_addr, a_wr_data,
      output cfg_k, cfg_signed, cfg_acc, start, res_rd_addr,
      input  busy, done, err, res_rd_data
   );

   modport slave (
      input  w_wr_en, w_wr_addr, w_wr_data, a_wr_en, a_wr_addr, a_wr_data,
      input  cfg_k, cfg_signed, cfg_acc, start, res_rd_addr,
      output busy, done, err, res_rd_data
   );

endinterface

// File: rtl/systolic_matmul_tiled_mac_pe.sv
// Output-stationary MAC cell: accumulates north*west and forwards both
// operands one cycle later to the south and east neighbours.
module mac_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  flush_i,
   input  logic                  en_signed_i,
   input  logic [DATA_WIDTH-1:0] north_i,
   input  logic [DATA_WIDTH-1:0] west_i,
   output logic [DATA_WIDTH-1:0] south_o,
   output logic [DATA_WIDTH-1:0] east_o,
   output logic [ACC_WIDTH-1:0]  acc_o
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]  prod_sgn_s;
   logic [PW-1:0]         prod_uns_s;
   logic [ACC_WIDTH-1:0]  prod_ext_s;
   logic [ACC_WIDTH-1:0]  acc_q;
   logic [DATA_WIDTH-1:0] south_q;
   logic [DATA_WIDTH-1:0] east_q;

   assign prod_sgn_s = $signed(north_i) * $signed(west_i);
   assign prod_uns_s = north_i * west_i;

   always_comb begin
      prod_ext_s = {ACC_WIDTH{1'b0}};
      if (en_signed_i) begin
         prod_ext_s = ACC_WIDTH'(prod_sgn_s);
      end else begin
         prod_ext_s = ACC_WIDTH'(prod_uns_s);
      end
   end

   // Flush zeroes the forwarding path; the accumulator is held unless clr_i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= {ACC_WIDTH{1'b0}};
         south_q <= {DATA_WIDTH{1'b0}};
         east_q  <= {DATA_WIDTH{1'b0}};
      end else if (flush_i) begin
         acc_q   <= clr_i ? {ACC_WIDTH{1'b0}} : acc_q;
         south_q <= {DATA_WIDTH{1'b0}};
         east_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         acc_q   <= acc_q + prod_ext_s;
         south_q <= north_i;
         east_q  <= west_i;
      end
   end

   assign south_o = south_q;
   assign east_o  = east_q;
   assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_matmul_tiled.sv
// Compute tile: operand buffers, run FSM, skewed feed staging, PE array and
// registered result read port.
module systolic_matmul_tiled import systolic_pkg::*; #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int K_MAX      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
) (
   input logic clk,
   input logic rst,
   systolic_matmul_tiled_if.slave bus
);
   localparam int W_DEPTH = K_MAX * COLS;
   localparam int A_DEPTH = ROWS * K_MAX;
   localparam int R_DEPTH = ROWS * COLS;
   localparam int WAW     = addr_w(W_DEPTH);
   localparam int AAW     = addr_w(A_DEPTH);
   localparam int KW      = addr_w(K_MAX + 1);
   localparam int CW      = addr_w(K_MAX + ROWS + COLS);

   state_e                state_q;
   logic [CW-1:0]         t_q;
   logic [KW-1:0]         k_q;
   logic                  signed_q, acc_mode_q, busy_q, done_q, err_q;
   logic [ACC_WIDTH-1:0]  res_q;
   logic [DATA_WIDTH-1:0] w_buf_q [W_DEPTH];
   logic [DATA_WIDTH-1:0] a_buf_q [A_DEPTH];
   logic [DATA_WIDTH-1:0] stage_n_q [COLS];
   logic [DATA_WIDTH-1:0] stage_n_d [COLS];
   logic [DATA_WIDTH-1:0] stage_w_q [ROWS];
   logic [DATA_WIDTH-1:0] stage_w_d [ROWS];
   logic [DATA_WIDTH-1:0] south_s [ROWS][COLS];
   logic [DATA_WIDTH-1:0] east_s [ROWS][COLS];
   logic [ACC_WIDTH-1:0]  acc_s [R_DEPTH];
   logic                  k_ok_s, wr_busy_s, pe_clr_s, pe_flush_s;
   logic [CW-1:0]         feed_last_s;

   assign k_ok_s      = (bus.cfg_k != {KW{1'b0}}) && (int'(bus.cfg_k) <= K_MAX);
   assign wr_busy_s   = (bus.w_wr_en | bus.a_wr_en) & busy_q;
   assign feed_last_s = CW'(int'(k_q) + ROWS + COLS - 3);
   assign pe_flush_s  = (state_q == ST_CLEAR);
   assign pe_clr_s    = pe_flush_s & ~acc_mode_q;

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.res_rd_data = res_q;

   // Operand buffers are not reset; writes land only while idle.
   always_ff @(posedge clk) begin
      if (bus.w_wr_en && state_q == ST_IDLE && int'(bus.w_wr_addr) < W_DEPTH) begin
         w_buf_q[bus.w_wr_addr] <= bus.w_wr_data;
      end
      if (bus.a_wr_en && state_q == ST_IDLE && int'(bus.a_wr_addr) < A_DEPTH) begin
         a_buf_q[bus.a_wr_addr] <= bus.a_wr_data;
      end
   end

   // Skewed wavefront: column c sees W[t-c][c], row r sees A[r][t-r].
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         stage_n_d[c] = {DATA_WIDTH{1'b0}};
         if (int'(t_q) >= c && int'(t_q) - c < int'(k_q)) begin
            stage_n_d[c] = w_buf_q[WAW'(w_index(int'(t_q) - c, c, COLS))];
         end else begin
            stage_n_d[c] = {DATA_WIDTH{1'b0}};
         end
      end
      for (int r = 0; r < ROWS; r++) begin
         stage_w_d[r] = {DATA_WIDTH{1'b0}};
         if (int'(t_q) >= r && int'(t_q) - r < int'(k_q)) begin
            stage_w_d[r] = a_buf_q[AAW'(a_index(r, int'(t_q) - r, K_MAX))];
         end else begin
            stage_w_d[r] = {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Staging carries data only during FEED so the array sees zeros otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < COLS; c++) stage_n_q[c] <= {DATA_WIDTH{1'b0}};
         for (int r = 0; r < ROWS; r++) stage_w_q[r] <= {DATA_WIDTH{1'b0}};
      end else begin
         for (int c = 0; c < COLS; c++)
            stage_n_q[c] <= (state_q == ST_FEED) ? stage_n_d[c] : {DATA_WIDTH{1'b0}};
         for (int r = 0; r < ROWS; r++)
            stage_w_q[r] <= (state_q == ST_FEED) ? stage_w_d[r] : {DATA_WIDTH{1'b0}};
      end
   end

   // Run control with registered busy/done/err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         t_q        <= {CW{1'b0}};
         k_q        <= {KW{1'b0}};
         signed_q   <= 1'b0;
         acc_mode_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= wr_busy_s;
         case (state_q)
            ST_IDLE: begin
               if (bus.start && k_ok_s) begin
                  state_q    <= ST_CLEAR;
                  k_q        <= bus.cfg_k;
                  signed_q   <= bus.cfg_signed;
                  acc_mode_q <= bus.cfg_acc;
                  busy_q     <= 1'b1;
               end else if (bus.start) begin
                  err_q <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               state_q <= ST_FEED;
               t_q     <= {CW{1'b0}};
            end
            ST_FEED: begin
               if (t_q == feed_last_s) begin
                  state_q <= ST_DRAIN;
                  t_q     <= {CW{1'b0}};
               end else begin
                  t_q <= t_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_DRAIN: begin
               if (int'(t_q) == DRAIN_CYCLES - 1) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  t_q <= t_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [DATA_WIDTH-1:0] n_in_s, w_in_s;
         if (r == 0) begin : g_n_edge
            assign n_in_s = stage_n_q[c];
         end else begin : g_n_inner
            assign n_in_s = south_s[r-1][c];
         end
         if (c == 0) begin : g_w_edge
            assign w_in_s = stage_w_q[r];
         end else begin : g_w_inner
            assign w_in_s = east_s[r][c-1];
         end
         mac_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (pe_clr_s),
            .flush_i    (pe_flush_s),
            .en_signed_i(signed_q),
            .north_i    (n_in_s),
            .west_i     (w_in_s),
            .south_o    (south_s[r][c]),
            .east_o     (east_s[r][c]),
            .acc_o      (acc_s[r*COLS+c])
         );
      end
   end

   // Registered result read; out-of-range addresses read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= {ACC_WIDTH{1'b0}};
      end else if (int'(bus.res_rd_addr) < R_DEPTH) begin
         res_q <= acc_s[bus.res_rd_addr];
      end else begin
         res_q <= {ACC_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_systolic_matmul_tiled.sv
// Directed bench for the 4x4, K_MAX=8, INT8 configuration of the tile.
module tb_systolic_matmul_tiled;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   systolic_matmul_tiled_if bus_if ();
   systolic_matmul_tiled dut (.clk(clk), .rst(rst), .bus(bus_if));

   always #5 clk = ~clk;

   task automatic wr_w(input int addr, input int data);
      @(negedge clk);
      bus_if.w_wr_en = 1'b1; bus_if.w_wr_addr = 5'(addr); bus_if.w_wr_data = 8'(data);
      @(negedge clk);
      bus_if.w_wr_en = 1'b0;
   endtask

   task automatic wr_a(input int addr, input int data);
      @(negedge clk);
      bus_if.a_wr_en = 1'b1; bus_if.a_wr_addr = 5'(addr); bus_if.a_wr_data = 8'(data);
      @(negedge clk);
      bus_if.a_wr_en = 1'b0;
   endtask

   task automatic rd(input int addr, output logic [23:0] d);
      @(negedge clk);
      bus_if.res_rd_addr = 4'(addr);
      @(posedge clk);
      #1 d = bus_if.res_rd_data;
   endtask

   // Starts a run and returns edges from the accepting edge to done (bounded).
   task automatic run(input int k, input logic sgn, input logic acc,
                      output int edges, output logic busy_at_start);
      @(negedge clk);
      bus_if.cfg_k = 4'(k); bus_if.cfg_signed = sgn; bus_if.cfg_acc = acc; bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      busy_at_start = bus_if.busy;
      edges = 0;
      while (bus_if.done !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1 edges++;
      end
   endtask

   task automatic load_identity();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) wr_a(r*8 + k, (r == k) ? 1 : 0);
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < 4; c++) wr_w(k*4 + c, k*4 + c + 1);
   endtask

   task automatic test_reset();
      logic [23:0] got;
      checks++;
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_status busy=%b done=%b err=%b expected 000", bus_if.busy, bus_if.done, bus_if.err);
      end
      for (int i = 0; i < 16; i++) begin
         rd(i, got);
         checks++;
         if (got !== 24'd0) begin errors++; $display("FAIL reset_res[%0d] got %0d expected 0", i, got); end
      end
   endtask

   task automatic test_identity();
      int edges; logic b0; logic [23:0] got;
      load_identity();
      run(4, 1'b0, 1'b0, edges, b0);
      checks++;
      if (b0 !== 1'b1) begin errors++; $display("FAIL ident_busy got %b expected 1", b0); end
      checks++;
      if (edges !== 13) begin errors++; $display("FAIL ident_latency got %0d expected 13", edges); end
      checks++;
      if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL ident_busy_at_done got %b expected 0", bus_if.busy); end
      @(posedge clk);
      #1 checks++;
      if (bus_if.done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse got %b expected 0", bus_if.done); end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            rd(r*4 + c, got);
            checks++;
            if (got !== 24'(r*4 + c + 1)) begin
               errors++; $display("FAIL ident_C[%0d][%0d] got %0d expected %0d", r, c, got, r*4 + c + 1);
            end
         end
   endtask

   task automatic test_signed();
      int edges; logic b0; logic [23:0] got;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 8; k++) wr_a(r*8 + k, 8'hFF);
      for (int i = 0; i < 32; i++) wr_w(i, 3);
      run(8, 1'b1, 1'b0, edges, b0);
      checks++;
      if (edges !== 17) begin errors++; $display("FAIL signed_latency got %0d expected 17", edges); end
      for (int i = 0; i < 16; i++) begin
         rd(i, got);
         checks++;
         if (got !== 24'hFFFFE8) begin errors++; $display("FAIL signed_C[%0d] got %h expected FFFFE8", i, got); end
      end
      run(8, 1'b0, 1'b0, edges, b0);
      for (int i = 0; i < 16; i++) begin
         rd(i, got);
         checks++;
         if (got !== 24'd6120) begin errors++; $display("FAIL unsigned_C[%0d] got %0d expected 6120", i, got); end
      end
   endtask

   task automatic test_accumulate();
      int edges; logic b0; logic [23:0] got; logic [23:0] exp_v;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 2; k++) wr_a(r*8 + k, 1);
      for (int i = 0; i < 8; i++) wr_w(i, 1);
      for (int pass = 0; pass < 3; pass++) begin
         run(2, 1'b0, (pass == 1) ? 1'b1 : 1'b0, edges, b0);
         exp_v = (pass == 1) ? 24'd4 : 24'd2;
         for (int i = 0; i < 16; i++) begin
            rd(i, got);
            checks++;
            if (got !== exp_v) begin
               errors++; $display("FAIL acc_pass%0d_C[%0d] got %0d expected %0d", pass, i, got, exp_v);
            end
         end
      end
   endtask

   task automatic test_k1();
      int edges; logic b0; logic [23:0] got;
      for (int r = 0; r < 4; r++) wr_a(r*8, r + 1);
      for (int c = 0; c < 4; c++) wr_w(c, c + 1);
      run(1, 1'b0, 1'b0, edges, b0);
      checks++;
      if (edges !== 10) begin errors++; $display("FAIL k1_latency got %0d expected 10", edges); end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            rd(r*4 + c, got);
            checks++;
            if (got !== 24'((r + 1) * (c + 1))) begin
               errors++; $display("FAIL k1_C[%0d][%0d] got %0d expected %0d", r, c, got, (r + 1) * (c + 1));
            end
         end
   endtask

   task automatic test_bad_k();
      int bad [2] = '{0, 9};
      foreach (bad[i]) begin
         @(negedge clk);
         bus_if.cfg_k = 4'(bad[i]); bus_if.cfg_acc = 1'b0; bus_if.start = 1'b1;
         @(posedge clk);
         #1 bus_if.start = 1'b0;
         checks++;
         if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL badk%0d err=%b busy=%b expected err=1 busy=0", bad[i], bus_if.err, bus_if.busy);
         end
         @(posedge clk);
         #1 checks++;
         if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL badk%0d_after err=%b busy=%b expected 0 0", bad[i], bus_if.err, bus_if.busy);
         end
      end
   endtask

   task automatic test_busy_write();
      int edges; logic [23:0] got;
      @(negedge clk);
      bus_if.cfg_k = 4'd1; bus_if.cfg_signed = 1'b0; bus_if.cfg_acc = 1'b0; bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus_if.w_wr_en = 1'b1; bus_if.w_wr_addr = 5'd0; bus_if.w_wr_data = 8'h63;
      @(posedge clk);
      #1 checks++;
      if (bus_if.err !== 1'b1) begin errors++; $display("FAIL busywr_err got %b expected 1", bus_if.err); end
      @(negedge clk);
      bus_if.w_wr_en = 1'b0;
      @(posedge clk);
      #1 checks++;
      if (bus_if.err !== 1'b0) begin errors++; $display("FAIL busywr_err_pulse got %b expected 0", bus_if.err); end
      edges = 3;
      while (bus_if.done !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1 edges++;
      end
      checks++;
      if (edges !== 10) begin errors++; $display("FAIL busywr_latency got %0d expected 10", edges); end
      for (int r = 0; r < 4; r++) begin
         rd(r*4, got);
         checks++;
         if (got !== 24'(r + 1)) begin errors++; $display("FAIL busywr_C[%0d][0] got %0d expected %0d", r, got, r + 1); end
      end
   endtask

   task automatic test_reset_mid();
      int edges; logic b0; logic [23:0] got;
      load_identity();
      @(negedge clk);
      bus_if.cfg_k = 4'd4; bus_if.cfg_signed = 1'b0; bus_if.cfg_acc = 1'b0; bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1 checks++;
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
         errors++; $display("FAIL midrst_status busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd(i, got);
         checks++;
         if (got !== 24'd0) begin errors++; $display("FAIL midrst_res[%0d] got %0d expected 0", i, got); end
      end
      run(4, 1'b0, 1'b1, edges, b0);
      for (int i = 0; i < 16; i++) begin
         rd(i, got);
         checks++;
         if (got !== 24'(i + 1)) begin errors++; $display("FAIL midrst_rerun_C[%0d] got %0d expected %0d", i, got, i + 1); end
      end
   endtask

   initial begin
      bus_if.w_wr_en = 1'b0; bus_if.w_wr_addr = 5'd0; bus_if.w_wr_data = 8'd0;
      bus_if.a_wr_en = 1'b0; bus_if.a_wr_addr = 5'd0; bus_if.a_wr_data = 8'd0;
      bus_if.cfg_k = 4'd0; bus_if.cfg_signed = 1'b0; bus_if.cfg_acc = 1'b0;
      bus_if.start = 1'b0; bus_if.res_rd_addr = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_identity();
      test_signed();
      test_accumulate();
      test_k1();
      test_bad_k();
      test_busy_write();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
